// File: rtl/alu_sequencer.sv
// Issue/write-back stage around an external 16-bit ALU: accepts one instruction,
// drives registered ALU operands, captures result and flags, and writes them back.
module alu_sequencer #(
  parameter int NREGS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [2:0]  in_rd,
  input  logic [2:0]  in_ra,
  input  logic [2:0]  in_rb,
  input  logic        in_imm_en,
  input  logic [15:0] in_imm,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_y,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic        alu_z,
  output logic [3:0]  status,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  input  logic [2:0]  dbg_raddr,
  output logic [15:0] dbg_rdata
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t      state, next_state;
  logic [15:0] regs [NREGS];
  logic [2:0]  rd_q;
  logic [15:0] res;
  logic [3:0]  flags;
  logic        accept;
  logic        reserved;

  assign accept   = in_valid && in_ready;
  assign reserved = alu_op[2] && alu_op[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = EXEC;
      EXEC:    next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Write-back fields read as zero outside an actual register write.
  always_comb begin
    in_ready = 1'b0;
    wb_valid = 1'b0;
    wb_rd    = 3'd0;
    wb_data  = 16'd0;
    case (state)
      IDLE: in_ready = 1'b1;
      WB: begin
        if (!reserved) begin
          wb_valid = 1'b1;
          wb_rd    = rd_q;
          wb_data  = res;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= 16'd0;
      alu_b  <= 16'd0;
      alu_op <= 3'd0;
      rd_q   <= 3'd0;
      res    <= 16'd0;
      flags  <= 4'd0;
      status <= 4'd0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 16'd0;
    end else begin
      if (accept) begin
        alu_a  <= regs[in_ra];
        alu_b  <= in_imm_en ? in_imm : regs[in_rb];
        alu_op <= in_op;
        rd_q   <= in_rd;
      end
      if (state == EXEC) begin
        res   <= alu_y;
        flags <= {alu_c, alu_v, alu_n, alu_z};
      end
      if (state == WB && !reserved) begin
        regs[rd_q] <= res;
        status     <= flags;
      end
    end
  end

  assign dbg_rdata = regs[dbg_raddr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed scenarios plus random instructions,
// with a behavioural ALU driving the DUT and an arithmetic reference model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0, in_rd = 3'd0, in_ra = 3'd0, in_rb = 3'd0;
  logic        in_imm_en = 1'b0;
  logic [15:0] in_imm = 16'd0;
  logic [15:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_op;
  logic        alu_c, alu_v, alu_n, alu_z;
  logic [3:0]  status;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic [2:0]  dbg_raddr = 3'd0;
  logic [15:0] dbg_rdata;

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  alu_sequencer #(.NREGS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
    .in_imm_en(in_imm_en), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
    .status(status), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Stand-in for the real ALU, bit-level as the hardware computes it.
  always_comb begin
    logic [16:0] t;
    t     = 17'd0;
    alu_y = 16'd0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      3'd0: begin
        t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y = t[15:0]; alu_c = t[16];
        alu_v = (alu_a[15] == alu_b[15]) && (alu_y[15] != alu_a[15]);
      end
      3'd1: begin
        t = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
        alu_y = t[15:0]; alu_c = t[16];
        alu_v = (alu_a[15] != alu_b[15]) && (alu_y[15] != alu_a[15]);
      end
      3'd2: alu_y = alu_a & alu_b;
      3'd3: alu_y = alu_a | alu_b;
      3'd4: alu_y = alu_a ^ alu_b;
      3'd5: alu_y = ~alu_a;
      default: alu_y = 16'd0;
    endcase
    alu_n = (alu_op < 3'd2) ? alu_y[15] : 1'b0;
    alu_z = (alu_y == 16'd0);
  end

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    logic [3:0]  st;
  } wb_t;

  wb_t         sbq[$];
  logic [15:0] mregs[8];
  logic [3:0]  mstatus;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference semantics from integer arithmetic: signed range for V, unsigned compare for C.
  function automatic void ref_exec(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] y, output logic [3:0] st, output bit wr);
    int sa, sb, s, ua, ub;
    logic c, v;
    sa = $signed(a); sb = $signed(b); ua = int'(a); ub = int'(b);
    c = 1'b0; v = 1'b0; wr = 1'b1; y = 16'd0;
    case (op)
      3'd0: begin s = sa + sb; y = 16'(ua + ub); c = (ua + ub) > 65535; v = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; y = 16'(ua - ub); c = (ua >= ub);        v = (s > 32767) || (s < -32768); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = ~a;
      default: wr = 1'b0;
    endcase
    st = {c, v, (op < 3'd2) ? y[15] : 1'b0, y == 16'd0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
    mstatus = 4'd0;
    sbq.delete();
  endtask

  // Drives one instruction, waits (bounded) for acceptance, then updates the model.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                               input logic [2:0] rb, input logic imm_en, input logic [15:0] imm,
                               input bit record, output int acc_cycle, output int waits);
    logic [15:0] b, y;
    logic [3:0]  st;
    bit wr;
    bit ok;
    ok = 0; waits = 0; acc_cycle = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_ra = ra; in_rb = rb;
    in_imm_en = imm_en; in_imm = imm;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        acc_cycle = cycle;
      end else begin
        waits++;
        @(negedge clk);
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    else if (record) begin
      b = imm_en ? imm : mregs[rb];
      ref_exec(op, mregs[ra], b, y, st, wr);
      if (wr) begin
        mregs[rd] = y;
        mstatus = st;
        sbq.push_back('{rd, y, st});
      end
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (in_ready) ok = 1;
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_status"}, 32'(status), 32'(mstatus));
    for (int i = 0; i < 8; i++) begin
      dbg_raddr = 3'(i);
      #0;
      check($sformatf("%s_r%0d", tag, i), 32'(dbg_rdata), 32'(mregs[i]));
    end
  endtask

  // Monitor: pops the scoreboard on every write-back, then checks status one cycle later.
  bit       chk_status = 0;
  logic [3:0] exp_status;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_status) begin
        check("wb_status", 32'(status), 32'(exp_status));
        chk_status = 0;
      end
      if (rst_n && wb_valid) begin
        if (sbq.size() == 0) begin
          check("wb_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          wb_t e;
          e = sbq.pop_front();
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", 32'(wb_data), 32'(e.data));
          exp_status = e.st;
          chk_status = 1;
        end
      end
    end
  end

  initial begin
    int a0, a1, w0, w1;
    model_reset();

    // Reset asserted mid-cycle, released on a falling edge.
    #3 rst_n = 1'b0;
    #14;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst");

    applyStimulus(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF, 1, a0, w0);
    wait_done();
    check("ovf1_status", 32'(status), 32'h0);
    applyStimulus(3'd0, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001, 1, a0, w0);
    wait_done();
    check("ovf2_status", 32'(status), 32'b0110);
    applyStimulus(3'd1, 3'd3, 3'd1, 3'd1, 1'b0, 16'hAAAA, 1, a0, w0);
    wait_done();
    check("sub0_status", 32'(status), 32'b1001);

    // Back-to-back with in_valid held high; second instruction reads the first's result.
    applyStimulus(3'd4, 3'd4, 3'd1, 3'd0, 1'b1, 16'hFFFF, 1, a0, w0);
    applyStimulus(3'd5, 3'd5, 3'd4, 3'd0, 1'b0, 16'h0000, 1, a1, w1);
    check("b2b_spacing", 32'(a1 - a0), 32'd3);
    check("b2b_ready_low", 32'(w1), 32'd2);
    wait_done();
    check("b2b_status", 32'(status), 32'h0);
    dbg_raddr = 3'd4; #0 check("r4_const", 32'(dbg_rdata), 32'h8000);
    dbg_raddr = 3'd5; #0 check("r5_const", 32'(dbg_rdata), 32'h7FFF);
    dbg_raddr = 3'd2; #0 check("r2_const", 32'(dbg_rdata), 32'h8000);
    checkOutput("dir");

    // Reserved op: no write, status held, ready again three cycles after accept.
    applyStimulus(3'd6, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0000, 1, a0, w0);
    applyStimulus(3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1, a1, w1);
    check("rsv_spacing", 32'(a1 - a0), 32'd3);
    wait_done();
    checkOutput("rsv");

    // Abort in EXEC: reset clears everything, no write-back is expected.
    applyStimulus(3'd0, 3'd7, 3'd0, 3'd0, 1'b1, 16'h1234, 0, a0, w0);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #4;
    check("abort_wb_valid", 32'(wb_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_wb", 32'(wb_valid), 32'd0);
    end
    checkOutput("abort");

    for (int n = 0; n < 40; n++) begin
      applyStimulus(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
                    1'($urandom), 16'($urandom), 1, a0, w0);
      if ($urandom_range(0, 1) == 1) begin
        wait_done();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    wait_done();
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    checkOutput("rand");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
